// File: rtl/fcl_requant_out_if.sv
// fcl_requant_out_if: accumulator-in / requantized-lane-out stream bundle.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. Once valid is raised it stays high, with its payload stable, until
// that transfer completes. ready may rise or fall at any time.
// The slave modport is the requantizer's view. The master modport is the
// environment's view: producer of vectors and consumer of lanes.
// dbg_state mirrors the requantizer FSM state so that checkers can bind to it.
interface fcl_requant_out_if #(
  parameter int DATAWIDTH    = 8,
  parameter int PARALLEL_NUM = 4
);
  localparam int LW = $clog2(PARALLEL_NUM);

  logic                                acc_valid;
  logic [PARALLEL_NUM*2*DATAWIDTH-1:0] acc_in;
  logic                                acc_ready;
  logic                                out_valid;
  logic                                out_ready;
  logic [DATAWIDTH-1:0]                out_data;
  logic [LW-1:0]                       out_lane;
  logic                                out_last;
  logic                                out_sat;
  logic [0:0]                          dbg_state;

  modport master (
    output acc_valid, acc_in, out_ready,
    input  acc_ready, out_valid, out_data, out_lane, out_last, out_sat, dbg_state
  );

  modport slave (
    input  acc_valid, acc_in, out_ready,
    output acc_ready, out_valid, out_data, out_lane, out_last, out_sat, dbg_state
  );
endinterface

// File: rtl/fcl_requant_out.sv
// fcl_requant_out: captures one vector of wide signed accumulator lanes, then
// streams the lanes out one per beat. Each lane is requantized to DATAWIDTH bits
// with a round-half-up arithmetic shift, saturation and an optional ReLU.
// Optional build macro FCL_REQUANT_BINARIZE_EN: when it is defined, each lane
// becomes +1 or -1 according to its sign, and out_sat stays at 0.
module fcl_requant_out #(
  parameter int DATAWIDTH    = 8,
  parameter int PARALLEL_NUM = 4,
  parameter int SHIFT        = 4,
  parameter int RELU         = 0
) (
  input logic               clk,
  input logic               rst,
  fcl_requant_out_if.slave  io
);
  localparam int AW = 2 * DATAWIDTH;
  localparam int LW = $clog2(PARALLEL_NUM);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [LW-1:0] LANE_LAST = LW'(PARALLEL_NUM - 1);

  // The rounding constant is half of one output LSB. It is zero when SHIFT is 0.
  localparam logic signed [AW:0] RND  = (AW+1)'((2 ** SHIFT) >> 1);
  localparam logic signed [AW:0] MAXV = (AW+1)'((2 ** (DATAWIDTH - 1)) - 1);
  localparam logic signed [AW:0] MINV = -MAXV - 1;

  logic [0:0]            state_q;
  logic [LW-1:0]         lane_q;
  logic signed [AW-1:0]  buf_q [PARALLEL_NUM];

  logic signed [AW-1:0]  cur;
  logic [DATAWIDTH-1:0]  q;
  logic                  q_sat;

  // State and lane counter. Reset drops any beats that are still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.acc_valid) begin
            state_q <= ST_SEND;
            lane_q  <= '0;
          end
        end
        ST_SEND: begin
          if (io.out_ready) begin
            if (lane_q == LANE_LAST) begin
              state_q <= ST_IDLE;
              lane_q  <= '0;
            end else begin
              lane_q <= lane_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          lane_q  <= '0;
        end
      endcase
    end
  end

  // Vector buffer: it loads only on an accepted capture. Its contents after a
  // reset do not matter, so it has no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && io.acc_valid) begin
      for (int i = 0; i < PARALLEL_NUM; i++) begin
        buf_q[i] <= io.acc_in[i*AW +: AW];
      end
    end
  end

`ifdef FCL_REQUANT_BINARIZE_EN
  // Binary activation: +1 for a lane that is zero or positive, -1 otherwise.
  always_comb begin
    cur   = buf_q[lane_q];
    q     = cur[AW-1] ? {DATAWIDTH{1'b1}} : DATAWIDTH'(1);
    q_sat = 1'b0;
  end
`else
  logic signed [AW:0] ext;
  logic signed [AW:0] sum;
  logic signed [AW:0] r;

  // Requantize the current lane. The extra bit keeps the rounding add from
  // overflowing. Saturation is applied first, then ReLU.
  always_comb begin
    cur   = buf_q[lane_q];
    ext   = {cur[AW-1], cur};
    sum   = ext + RND;
    r     = sum >>> SHIFT;
    q     = r[DATAWIDTH-1:0];
    q_sat = 1'b0;
    if (r > MAXV) begin
      q     = MAXV[DATAWIDTH-1:0];
      q_sat = 1'b1;
    end else if (r < MINV) begin
      q     = MINV[DATAWIDTH-1:0];
      q_sat = 1'b1;
    end
    if (RELU != 0 && q[DATAWIDTH-1]) begin
      q     = '0;
      q_sat = 1'b0;
    end
  end
`endif

  // All handshake outputs come from registered state. Data and sat are gated
  // so that they read 0 whenever no beat is being offered.
  always_comb begin
    io.acc_ready = (state_q == ST_IDLE);
    io.out_valid = (state_q == ST_SEND);
    io.out_lane  = lane_q;
    io.out_last  = (state_q == ST_SEND) && (lane_q == LANE_LAST);
    io.out_data  = (state_q == ST_SEND) ? q : '0;
    io.out_sat   = (state_q == ST_SEND) ? q_sat : 1'b0;
    io.dbg_state = state_q;
  end
endmodule

// File: tb/tb_fcl_requant_out.sv
// tb_fcl_requant_out: two instances, RELU=0 (a) and RELU=1 (b), are driven in
// lockstep from the same stimulus. Each instance has its own expected-beat queue.
module tb_fcl_requant_out;
  localparam int D = 8;
  localparam int P = 4;
  localparam int W = 12; // {sat, lane[1:0], last, data[7:0]}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          acc_valid = 1'b0;
  logic [63:0]   acc_in = '0;
  logic          out_ready = 1'b0;

  logic [W-1:0]  exp_a_q[$];
  logic [W-1:0]  exp_b_q[$];
  int            tests = 0;
  int            fails = 0;
  int            beats_a = 0;

  fcl_requant_out_if #(.DATAWIDTH(D), .PARALLEL_NUM(P)) ifa ();
  fcl_requant_out_if #(.DATAWIDTH(D), .PARALLEL_NUM(P)) ifb ();

  assign ifa.acc_valid = acc_valid;
  assign ifa.acc_in    = acc_in;
  assign ifa.out_ready = out_ready;
  assign ifb.acc_valid = acc_valid;
  assign ifb.acc_in    = acc_in;
  assign ifb.out_ready = out_ready;

  fcl_requant_out #(.DATAWIDTH(D), .PARALLEL_NUM(P), .SHIFT(4), .RELU(0)) dut_a (
    .clk(clk), .rst(rst), .io(ifa.slave));
  fcl_requant_out #(.DATAWIDTH(D), .PARALLEL_NUM(P), .SHIFT(4), .RELU(1)) dut_b (
    .clk(clk), .rst(rst), .io(ifb.slave));

  // clock / reset
  always #5 clk = ~clk;

  // Expected values for each test vector. Lane 0 is in the LSBs.
  // da/db hold the data for instance a/b. sa/sb hold the sat bit of each lane.
`ifdef FCL_REQUANT_BINARIZE_EN
  localparam logic [31:0] BASIC_DA = {8'h01, 8'h01, 8'hFF, 8'h01};
  localparam logic [3:0]  BASIC_SA = 4'b0000;
  localparam logic [31:0] BASIC_DB = {8'h01, 8'h01, 8'hFF, 8'h01};
  localparam logic [3:0]  BASIC_SB = 4'b0000;
`else
  localparam logic [31:0] BASIC_DA = {8'h01, 8'h00, 8'hFA, 8'h06};
  localparam logic [3:0]  BASIC_SA = 4'b0000;
  localparam logic [31:0] BASIC_DB = {8'h01, 8'h00, 8'h00, 8'h06};
  localparam logic [3:0]  BASIC_SB = 4'b0000;
`endif

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [W-1:0] mk(input logic [7:0] d, input logic s, input int l);
    logic [1:0] lb;
    lb = l[1:0];
    return {s, lb, (l == P - 1), d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic push_exp(input logic [31:0] da, input logic [3:0] sa,
                          input logic [31:0] db, input logic [3:0] sb, input int n);
    for (int i = 0; i < n; i++) begin
      exp_a_q.push_back(mk(da[i*8 +: 8], sa[i], i));
      exp_b_q.push_back(mk(db[i*8 +: 8], sb[i], i));
    end
  endtask

  // Present a vector and wait for it to be captured. After the capture edge,
  // check that the first beat is already on offer.
  task automatic start_vec(input logic [63:0] vec);
    int n;
    @(posedge clk); #1;
    acc_in    = vec;
    acc_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!ifa.acc_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("capture_wait", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    acc_valid = 1'b0;
    check("first_beat_a", {ifa.out_valid, ifa.acc_ready, 6'(ifa.out_lane)}, {1'b1, 1'b0, 6'd0});
    check("first_beat_b", {ifb.out_valid, ifb.acc_ready, 6'(ifb.out_lane)}, {1'b1, 1'b0, 6'd0});
  endtask

  // Send a vector with out_ready held high: four beats on four back-to-back
  // cycles, then acc_ready is high again on the very next cycle.
  task automatic run_vec(input string name, input logic [63:0] vec,
                         input logic [31:0] da, input logic [3:0] sa,
                         input logic [31:0] db, input logic [3:0] sb);
    push_exp(da, sa, db, sb, P);
    start_vec(vec);
    repeat (P) @(posedge clk);
    #1;
    check({name, "_ready_a"}, {ifa.acc_ready, ifa.out_valid}, 2'b10);
    check({name, "_ready_b"}, {ifb.acc_ready, ifb.out_valid}, 2'b10);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      beats_a++;
      if (exp_a_q.size() == 0) begin
        check("beat_a_unexpected", 32'(ifa.out_data), 32'hDEAD);
      end else begin
        check("beat_a", 32'({ifa.out_sat, ifa.out_lane, ifa.out_last, ifa.out_data}),
              32'(exp_a_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      if (exp_b_q.size() == 0) begin
        check("beat_b_unexpected", 32'(ifb.out_data), 32'hDEAD);
      end else begin
        check("beat_b", 32'({ifb.out_sat, ifb.out_lane, ifb.out_last, ifb.out_data}),
              32'(exp_b_q.pop_front()));
      end
    end
  end

  initial begin
    int b0;
    // Reset: a vector is held valid while rst is high and must not be captured.
    acc_in    = pack4(100, -100, 0, 8);
    acc_valid = 1'b1;
    #3;
    check("reset_a", 32'({ifa.acc_ready, ifa.out_valid, ifa.out_last, ifa.out_sat, ifa.out_lane, ifa.out_data}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}));
    check("reset_b", 32'({ifb.acc_ready, ifb.out_valid, ifb.out_last, ifb.out_sat, ifb.out_lane, ifb.out_data}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}));
    repeat (3) @(posedge clk);
    #1;
    check("reset_no_capture", {ifa.out_valid, ifb.out_valid}, 2'b00);
    acc_valid = 1'b0;
    rst = 1'b0;

    // Basic vector with out_ready held high.
    run_vec("basic", pack4(100, -100, 0, 8), BASIC_DA, BASIC_SA, BASIC_DB, BASIC_SB);

`ifdef FCL_REQUANT_BINARIZE_EN
    run_vec("binarize", pack4(0, -1, 32767, -32768),
            {8'hFF, 8'h01, 8'hFF, 8'h01}, 4'b0000,
            {8'hFF, 8'h01, 8'hFF, 8'h01}, 4'b0000);
`else
    run_vec("sat", pack4(5000, -5000, 2039, 2040),
            {8'h7F, 8'h7F, 8'h80, 8'h7F}, 4'b1011,
            {8'h7F, 8'h7F, 8'h00, 8'h7F}, 4'b1001);
    run_vec("relu", pack4(-5000, -8, -9, 40),
            {8'h03, 8'hFF, 8'h00, 8'h80}, 4'b0001,
            {8'h03, 8'h00, 8'h00, 8'h00}, 4'b0000);
    run_vec("extreme", pack4(0, -1, 32767, -32768),
            {8'h80, 8'h7F, 8'h00, 8'h00}, 4'b1100,
            {8'h00, 8'h7F, 8'h00, 8'h00}, 4'b0100);
`endif

    // Reset mid-SEND: only beats 0 and 1 are delivered.
    push_exp(BASIC_DA, BASIC_SA, BASIC_DB, BASIC_SB, 2);
    start_vec(pack4(100, -100, 0, 8));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_a", {ifa.out_valid, ifa.acc_ready, ifa.out_last, 1'b0, 4'(ifa.out_lane)}, 8'b0100_0000);
    check("rst_mid_b", {ifb.out_valid, ifb.acc_ready, ifb.out_last, 1'b0, 4'(ifb.out_lane)}, 8'b0100_0000);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_release", {ifa.acc_ready, ifa.out_valid, ifb.acc_ready, ifb.out_valid}, 4'b1010);
    run_vec("after_rst", pack4(100, -100, 0, 8), BASIC_DA, BASIC_SA, BASIC_DB, BASIC_SB);

    // Back-pressure on beat 2, with an intruding vector that must be ignored.
    b0 = beats_a;
    push_exp(BASIC_DA, BASIC_SA, BASIC_DB, BASIC_SB, P);
    start_vec(pack4(100, -100, 0, 8));
    acc_in    = pack4(5000, -5000, 2039, 2040);
    acc_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_a", {ifa.out_valid, ifa.acc_ready, 6'(ifa.out_lane), ifa.out_data},
            {1'b1, 1'b0, 6'd1, BASIC_DA[15:8]});
      check("hold_b", {ifb.out_valid, ifb.acc_ready, 6'(ifb.out_lane), ifb.out_data},
            {1'b1, 1'b0, 6'd1, BASIC_DB[15:8]});
    end
    out_ready = 1'b1;
    acc_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_ready", {ifa.acc_ready, ifa.out_valid, ifb.acc_ready, ifb.out_valid}, 4'b1010);
    check("bp_beats", 32'(beats_a - b0), 32'd4);
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_capture", {ifa.out_valid, ifb.out_valid}, 2'b00);

    // final report
    check("drain_a", 32'(exp_a_q.size()), 32'd0);
    check("drain_b", 32'(exp_b_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fcl_requant_out.md
# fcl_requant_out

Output stage directly downstream of the fixed-point fully-connected array. It captures one vector of PARALLEL_NUM wide signed accumulator results, requantizes each lane back to DATAWIDTH bits (rounding shift, saturation, optional ReLU), and streams the lanes out one per beat over a valid/ready handshake. The output feeds the next layer's single-value INPUT stream.

## Interface
Parameters:
- DATAWIDTH, 8: width of the output element; the accumulator lane width is 2*DATAWIDTH.
- PARALLEL_NUM, 4: lanes per captured vector (≥2).
- SHIFT, 4: arithmetic right shift applied before saturation (0 ≤ SHIFT < 2*DATAWIDTH).
- RELU, 0: 1 clamps negative results to 0.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. **Asynchronous, active-high.**
- acc_valid  in  1  accumulator vector present.
- acc_in  in  PARALLEL_NUM×2*DATAWIDTH  signed accumulator lanes, packed with lane 0 in the LSBs.
- acc_ready  out  1  block can capture a vector.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DATAWIDTH  signed requantized lane.
- out_lane  out  clog2(PARALLEL_NUM)  index of the lane on out_data.
- out_last  out  1  beat carries lane PARALLEL_NUM-1.
- out_sat  out  1  the current beat was saturated (qualified by out_valid).

## Operation
- FSM with two states, IDLE and SEND. Reset state is IDLE.
- IDLE:
  - acc_ready=1 and out_valid=0.
  - When acc_valid=1, register all lanes of acc_in into the vector buffer, set lane=0, and go to SEND.
- SEND:
  - acc_ready=0 and out_valid=1.
  - out_data, out_sat and out_lane are derived from buffer[lane].
  - When out_ready=1 and lane<PARALLEL_NUM-1: increment lane.
  - When out_ready=1 and lane=PARALLEL_NUM-1: return to IDLE.
  - When out_ready=0: hold. out_data and out_lane stay stable.
- Requantization, computed in 2*DATAWIDTH+1 bits:
  - If SHIFT>0: r = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up toward +inf. If SHIFT=0: r = acc.
  - Saturate r to the range [-2^(DATAWIDTH-1), 2^(DATAWIDTH-1)-1]. out_sat=1 when clamping occurred.
  - If RELU=1 and r<0: output 0 and out_sat=0. ReLU is applied after saturation.
- out_last = (lane == PARALLEL_NUM-1) && out_valid.
- acc_valid is ignored outside IDLE, so a producer must hold its vector until acc_ready is high.

## Timing
- Reset values:
  - state=IDLE, lane=0, out_valid=0, out_last=0, out_sat=0, out_data=0, out_lane=0, acc_ready=1.
  - While rst is high, no capture occurs.
- Capture to first beat: 1 cycle. out_valid rises on the edge after the acc_valid&&acc_ready edge.
- Throughput: at best PARALLEL_NUM+1 cycles per vector, because acc_ready does not reassert until the cycle after the last beat is accepted.
- acc_ready and out_valid are functions of registered state only. There is no combinational path from out_ready or acc_valid to either signal.
- Reset asserted mid-SEND drops the remaining beats immediately and asynchronously. The buffer contents are don't-care.
- out_ready may be held high continuously, giving one beat per cycle. Back-pressure can be applied on any beat, including the last.

## Configuration
- Macro: FCL_REQUANT_BINARIZE_EN.
- **Defined:**
  - out_data = +1 when acc ≥ 0, otherwise -1 (8'h01 / 8'hFF for DATAWIDTH=8).
  - SHIFT, RELU and the saturation logic are bypassed, and out_sat is tied to 0.
  - Used for binary-activation layers.
- **Undefined:** the requantization path described above.

## Test plan
- Reset mid-SEND: assert rst after beat 1 -> out_valid=0 asynchronously. After release, acc_ready=1 and lane=0, and the next vector starts at lane 0.
- Basic (D=8, P=4, SHIFT=4, RELU=0), acc_in lanes = {100, -100, 0, 8}, out_ready held high -> out_data 6, -6, 0, 1 on consecutive cycles. out_last on the 4th beat only. acc_ready=1 on the following cycle.
- Saturation: lanes = {5000, -5000, 2039, 2040} -> outputs 127 (sat=1), -128 (sat=1), 127 (sat=0), 127 (sat=1).
- ReLU (RELU=1): lanes = {-5000, -8, -9, 40} -> outputs 0, 0, -1→0, 3. out_sat=0 on every beat.
- Back-pressure: drop out_ready for 3 cycles on beat 2 -> out_data and out_lane hold. A second acc_valid presented during SEND is not captured (acc_ready=0). Total of 4 accepted beats.
- FCL_REQUANT_BINARIZE_EN defined: lanes = {0, -1, 32767, -32768} -> 8'h01, 8'hFF, 8'h01, 8'hFF. out_sat=0 on every beat.
